// File: rtl/clock_disp_scan.sv
// Time-to-BCD converter and 6-digit multiplexed 7-segment scanner (HH:MM:SS).
// Converts by repeated subtraction of ten and commits all six digits together.
module clock_disp_scan #(
    parameter int unsigned SCAN_DIV       = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_HR_LZ    = 1'b1
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_seconds,
    input  logic [7:0] i_mins,
    input  logic [7:0] i_hrs,
    input  logic       i_en,
    output logic [6:0] o_seg,
    output logic [5:0] o_dig_sel,
    output logic       o_busy,
    output logic       o_range_err
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state, state_next;
    logic [7:0]  rem_s, rem_m, rem_h;
    logic [3:0]  tens_s, tens_m, tens_h;
    logic [7:0]  pend_s, pend_m, pend_h;
    logic        pend_v;
    logic [5:0][3:0] digits;

    logic        flag_s, flag_m, flag_h;
    logic        done_s, done_m, done_h;
    logic        commit;
    logic        load_in, load_pend, pend_wr;

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [3:0]    cur_digit;
    logic          cur_blank;
    logic [6:0]    seg_raw;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            4'hF:    seg_decode = 7'h40;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    always_comb begin
        flag_s = rem_s > 8'd99;
        flag_m = rem_m > 8'd99;
        flag_h = rem_h > 8'd99;
        done_s = flag_s || (rem_s < 8'd10);
        done_m = flag_m || (rem_m < 8'd10);
        done_h = flag_h || (rem_h < 8'd10);
        commit = (state == CONV) && done_s && done_m && done_h;
    end

    always_comb begin
        state_next = state;
        load_in    = 1'b0;
        load_pend  = 1'b0;
        pend_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    load_in    = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (commit) begin
                    if (i_valid)     load_in    = 1'b1;
                    else if (pend_v) load_pend  = 1'b1;
                    else             state_next = IDLE;
                end else if (i_valid) begin
                    pend_wr = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state       <= IDLE;
            rem_s       <= '0;
            rem_m       <= '0;
            rem_h       <= '0;
            tens_s      <= '0;
            tens_m      <= '0;
            tens_h      <= '0;
            pend_s      <= '0;
            pend_m      <= '0;
            pend_h      <= '0;
            pend_v      <= 1'b0;
            digits      <= '0;
            o_range_err <= 1'b0;
        end else begin
            state <= state_next;

            if (load_in) begin
                rem_s  <= i_seconds;
                rem_m  <= i_mins;
                rem_h  <= i_hrs;
                tens_s <= '0;
                tens_m <= '0;
                tens_h <= '0;
            end else if (load_pend) begin
                rem_s  <= pend_s;
                rem_m  <= pend_m;
                rem_h  <= pend_h;
                tens_s <= '0;
                tens_m <= '0;
                tens_h <= '0;
            end else if (state == CONV) begin
                if (!done_s) begin rem_s <= rem_s - 8'd10; tens_s <= tens_s + 4'd1; end
                if (!done_m) begin rem_m <= rem_m - 8'd10; tens_m <= tens_m + 4'd1; end
                if (!done_h) begin rem_h <= rem_h - 8'd10; tens_h <= tens_h + 4'd1; end
            end

            // Only one pending slot: a newer strobe overwrites an unconsumed one.
            if (pend_wr) begin
                pend_s <= i_seconds;
                pend_m <= i_mins;
                pend_h <= i_hrs;
                pend_v <= 1'b1;
            end else if (commit) begin
                pend_v <= 1'b0;
            end

            if (commit) begin
                digits[0]   <= flag_s ? 4'hF : rem_s[3:0];
                digits[1]   <= flag_s ? 4'hF : tens_s;
                digits[2]   <= flag_m ? 4'hF : rem_m[3:0];
                digits[3]   <= flag_m ? 4'hF : tens_m;
                digits[4]   <= flag_h ? 4'hF : rem_h[3:0];
                digits[5]   <= flag_h ? 4'hF : tens_h;
                o_range_err <= flag_s || flag_m || flag_h;
            end
        end
    end

    assign o_busy = (state == CONV);

    always_comb begin
        case (idx)
            3'd0:    cur_digit = digits[0];
            3'd1:    cur_digit = digits[1];
            3'd2:    cur_digit = digits[2];
            3'd3:    cur_digit = digits[3];
            3'd4:    cur_digit = digits[4];
            3'd5:    cur_digit = digits[5];
            default: cur_digit = '0;
        endcase
        cur_blank = BLANK_HR_LZ && (idx == 3'd5) && (cur_digit == 4'd0);
        seg_raw   = cur_blank ? 7'h00 : seg_decode(cur_digit);
    end

    // Scanner free-runs even when disabled so re-enable resumes mid-sequence.
    always_ff @(posedge CLK) begin
        if (rst) begin
            presc     <= '0;
            idx       <= '0;
            o_dig_sel <= '0;
            o_seg     <= SEG_OFF;
        end else begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            if (i_en) begin
                o_dig_sel <= 6'b000001 << idx;
                o_seg     <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
            end else begin
                o_dig_sel <= '0;
                o_seg     <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_clock_disp_scan.sv
// Scoreboard bench for clock_disp_scan: stimulus queues expected conversions,
// a monitor checks busy length, range error and one scanned frame per conversion.
module tb_clock_disp_scan;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_seconds = '0;
    logic [7:0] i_mins = '0;
    logic [7:0] i_hrs = '0;
    logic       i_en = 1'b0;
    logic [6:0] o_seg;
    logic [5:0] o_dig_sel;
    logic       o_busy;
    logic       o_range_err;

    clock_disp_scan #(
        .SCAN_DIV(4),
        .SEG_ACTIVE_LOW(1'b1),
        .BLANK_HR_LZ(1'b1)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .i_valid(i_valid),
        .i_seconds(i_seconds),
        .i_mins(i_mins),
        .i_hrs(i_hrs),
        .i_en(i_en),
        .o_seg(o_seg),
        .o_dig_sel(o_dig_sel),
        .o_busy(o_busy),
        .o_range_err(o_range_err)
    );

    always #5 CLK = ~CLK;

    // Digit codes: 0-9 decimal, 4'hF dash, 4'hE blank. dg holds d5..d0 left to right.
    typedef struct packed {
        int          blen;
        logic [23:0] dg;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [6:0] seg_exp(input logic [3:0] code);
        case (code)
            4'd0: seg_exp = 7'h40;
            4'd1: seg_exp = 7'h79;
            4'd2: seg_exp = 7'h24;
            4'd3: seg_exp = 7'h30;
            4'd4: seg_exp = 7'h19;
            4'd5: seg_exp = 7'h12;
            4'd6: seg_exp = 7'h02;
            4'd7: seg_exp = 7'h78;
            4'd8: seg_exp = 7'h00;
            4'd9: seg_exp = 7'h10;
            4'hF: seg_exp = 7'h3F;
            default: seg_exp = 7'h7F;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        @(negedge CLK);
        i_valid   = v;
        i_hrs     = h;
        i_mins    = m;
        i_seconds = s;
    endtask

    task automatic expect_ep(input int blen, input logic [23:0] dg, input logic err);
        exp_t e;
        e.blen = blen;
        e.dg   = dg;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 60 && !idle; k++) begin
            @(negedge CLK);
            if (!o_busy) idle = 1'b1;
        end
        if (!idle) chk("busy_timeout", 32'(o_busy), 32'd0);
        repeat (40) @(negedge CLK);
    endtask

    // Monitor: a busy episode ending triggers a pop and a full-frame capture.
    initial begin
        int   blen = 0;
        bit   pb = 1'b0;
        exp_t e;
        logic [6:0] got [6];
        bit   seen [6];
        bit   all;
        logic [23:0] dg;
        forever begin
            @(negedge CLK);
            if (o_busy) begin
                blen++;
            end else if (pb) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_conversion", 32'(blen), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("busy_len", 32'(blen), 32'(e.blen));
                    chk("range_err", 32'(o_range_err), 32'(e.err));
                    for (int d = 0; d < 6; d++) seen[d] = 1'b0;
                    all = 1'b0;
                    for (int k = 0; k < 40 && !all; k++) begin
                        @(negedge CLK);
                        for (int d = 0; d < 6; d++)
                            if (o_dig_sel == (6'b000001 << d)) begin
                                got[d]  = o_seg;
                                seen[d] = 1'b1;
                            end
                        all = seen[0] && seen[1] && seen[2] && seen[3] && seen[4] && seen[5];
                    end
                    if (!all) chk("frame_timeout", 32'(all), 32'd1);
                    else begin
                        dg = e.dg;
                        for (int d = 0; d < 6; d++)
                            chk($sformatf("seg_digit%0d", d), 32'(got[d]), 32'(seg_exp(dg[d*4 +: 4])));
                    end
                end
                blen = 0;
            end
            pb = o_busy;
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_dig_sel", 32'(o_dig_sel), 32'h0);
        chk("rst_seg", 32'(o_seg), 32'h7F);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_range_err", 32'(o_range_err), 32'h0);
        rst  = 1'b0;
        i_en = 1'b1;

        // Scan walk: each digit 4 cycles, zeros with hours tens blanked
        for (int n = 1; n <= 26; n++) begin
            @(negedge CLK);
            chk("scan_sel", 32'(o_dig_sel), 32'(6'b000001 << (((n - 1) / 4) % 6)));
            chk("scan_seg", 32'(o_seg), (((n - 1) / 4) % 6 == 5) ? 32'h7F : 32'h40);
        end

        // 23:59:45 -> six CONV cycles
        expect_ep(6, 24'h235945, 1'b0);
        drive(1'b1, 8'd23, 8'd59, 8'd45);
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        wait_idle();

        // Out-of-range hours -> dashes, error set
        expect_ep(1, 24'hFF0700, 1'b1);
        drive(1'b1, 8'd120, 8'd7, 8'd0);
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        wait_idle();

        // 01:00:00 clears the error
        expect_ep(1, 24'hE10000, 1'b0);
        drive(1'b1, 8'd1, 8'd0, 8'd0);
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        wait_idle();

        // A=00:00:45, B=11:11:11 overwritten by C=12:34:56 in pending
        expect_ep(11, 24'h123456, 1'b0);
        drive(1'b1, 8'd0, 8'd0, 8'd45);
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b1, 8'd11, 8'd11, 8'd11);
        drive(1'b1, 8'd12, 8'd34, 8'd56);
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        wait_idle();

        // Strobe in the commit cycle beats a pending entry
        expect_ep(7, 24'hE00030, 1'b0);
        drive(1'b1, 8'd0, 8'd0, 8'd21);
        drive(1'b1, 8'd0, 8'd0, 8'd11);
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b1, 8'd0, 8'd0, 8'd30);
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        wait_idle();

        // Error set again, then reset in the 3rd CONV cycle of 00:59:59
        expect_ep(1, 24'hFF0700, 1'b1);
        drive(1'b1, 8'd120, 8'd7, 8'd0);
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        wait_idle();
        expect_ep(3, 24'hE00000, 1'b0);
        drive(1'b1, 8'd0, 8'd59, 8'd59);
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        @(negedge CLK);
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        chk("rst_abort_busy", 32'(o_busy), 32'h0);
        chk("rst_abort_err", 32'(o_range_err), 32'h0);
        wait_idle();

        // Display disable for 10 cycles, then resume at free-running index
        i_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("dis_sel", 32'(o_dig_sel), 32'h0);
            chk("dis_seg", 32'(o_seg), 32'h7F);
        end
        i_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk("reen_sel", 32'(o_dig_sel), 32'(6'b000001 << (((cyc - 1) / 4) % 6)));
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/clock_disp_scan.md
Name: clock_disp_scan

Overview:
- Downstream consumer of the digital clock's time outputs: seconds, minutes and hours (binary, 8-bit each) plus the one-cycle Valid update strobe.
- On each strobe it snapshots the time and converts each field to two BCD digits by iterative subtraction.
- It then drives a 6-digit multiplexed 7-segment display (HH:MM:SS) from committed digit registers.
- Runs on the same 1 kHz CLK as the clock core.

Parameters:
- SCAN_DIV, 4: CLK cycles each digit stays selected (must be >= 1).
- SEG_ACTIVE_LOW, 1: 1 = segment lit when its bit is 0; 0 = lit when bit is 1.
- BLANK_HR_LZ, 1: 1 = blank the hours-tens digit when it is 0.

Ports:
- CLK  in  1  system clock, 1 kHz.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  time-update strobe, driven by the clock core's Valid.
- i_seconds  in  8  binary seconds.
- i_mins  in  8  binary minutes.
- i_hrs  in  8  binary hours (12h or 24h, already muxed upstream).
- i_en  in  1  display enable.
- o_seg  out  7  segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW.
- o_dig_sel  out  6  one-hot digit select, active-high. Bit0 = seconds units, bit5 = hours tens.
- o_busy  out  1  conversion in progress.
- o_range_err  out  1  last committed snapshot had a field > 99.

Behaviour:
- Interface fact: one clock; reset is synchronous and active-high.
- Reset (rst sampled high at a CLK edge):
  - Digit regs = 0; pending buffer empty; FSM = IDLE.
  - Prescaler = 0; digit index = 0.
  - o_dig_sel = 0; o_seg = all-off; o_busy = 0; o_range_err = 0.
  - Reset mid-conversion aborts it; digit regs revert to 0.
- Conversion FSM (IDLE, CONV):
  - IDLE & i_valid: load working regs (rem_s/m/h = inputs, tens_x = 0); next state CONV; o_busy = 1 from the next cycle.
  - CONV, per cycle, for each field:
    - If 10 <= rem <= 99: rem -= 10, tens += 1.
    - If rem > 99: field is flagged out-of-range and treated as done.
  - Commit cycle = first CONV cycle in which every field is done (rem < 10 or flagged):
    - Write all 6 digit regs atomically.
    - Out-of-range field's two digits = code 0xF (dash).
    - o_range_err = OR of flags; recomputed at every commit.
  - Latency: CONV lasts T+1 cycles, T = max tens over in-range fields. New digits are visible on o_seg no earlier than the cycle after commit.
- Exit from the commit cycle, in priority order:
  1. i_valid in the commit cycle: load working regs from inputs, stay CONV, clear pending.
  2. Else if pending valid: load from the pending buffer, stay CONV, clear pending.
  3. Else: go to IDLE, o_busy = 0.
- Pending buffer:
  - i_valid during a non-commit CONV cycle writes a one-deep pending buffer (3x8 bits). The latest write wins; older entries are silently dropped.
- Scanner:
  - Prescaler counts 0..SCAN_DIV-1 and wraps. At wrap, digit index advances 0→5→0.
  - Both run regardless of i_en.
  - o_dig_sel and o_seg are registered: one cycle after the index/digit-reg change.
- Segment decode (before polarity inversion):
  - Digits 0-9: standard patterns (0 = a..f; 1 = b,c; 8 = all).
  - 0xF: g only (dash).
  - Blank: all off.
  - Hours tens == 0 with BLANK_HR_LZ = 1 → blank.
  - All-off is 7'h7F when SEG_ACTIVE_LOW = 1, else 7'h00.
- i_en = 0: o_dig_sel = 0, o_seg = all-off (registered, one-cycle delay). Conversion still runs.

Test Plan:
- Reset then i_en = 1, SCAN_DIV = 4 → o_dig_sel walks 000001→000010→…→100000→000001, 4 cycles each. Digit regs read 0,0,0,0,0,blank; o_seg for 0 = 7'h40 (active-low).
- i_valid with 23:59:45 → o_busy high for exactly 6 cycles. Committed digits 5,4,9,5,3,2; o_range_err = 0.
- i_valid with hrs = 8'd120, mins = 7, secs = 0 → 1 CONV cycle. Hours digits both dash (o_seg = 7'h3F); o_range_err = 1. A later valid 01:00:00 clears it.
- Three i_valid pulses on cycles 1, 3, 4 (values A, B, C):
  - A converts; B is overwritten by C in the pending buffer.
  - C converts immediately after A's commit; B is never displayed.
  - i_valid coinciding with the commit cycle is taken directly.
- rst asserted during the 3rd CONV cycle of 59:59 → next cycle o_busy = 0, digits 0, o_range_err = 0. No commit occurs.
- i_en low for 10 cycles mid-scan → o_dig_sel = 0, o_seg = 7'h7F. Re-enable resumes at the index the free-running counter has reached.
